ddr_ex_read_checker: RTL
========================

// Module: ddr_ex_read_checker
// PURPOSE
//  Downstream consumer of the 8-bit LFSR pattern generator in the DDR example test driver.
//  Regenerates the expected write pattern per byte lane and compares it against memory read-back beats.
//  Counts mismatching beats and reports sticky pass/fail to the driver FSM and the status registers.
// PARAMETERS
//  DATA_WIDTH    32  read-data width; multiple of 8; NUM_LANES = DATA_WIDTH/8
//  SEED          32  lane i seed = SEED+i; elaboration error unless 1 <= SEED and SEED+NUM_LANES-1 <= 255
//  BEAT_WIDTH    16  width of num_beats and the beat counter
//  ERRCNT_WIDTH  16  width of err_count (saturating)
// PORTS
//  clk             in   1             clock
//  reset           in   1             async active-high reset
//  start           in   1             1-cycle pulse: reseed lanes, clear status, begin check
//  num_beats       in   BEAT_WIDTH    beats to check; sampled on start
//  rd_valid        in   1             read-back beat valid
//  rd_data         in   DATA_WIDTH    read-back beat
//  busy            out  1             state == CHECK
//  done            out  1             state == DONE
//  pass            out  1             done && err_count == 0 && !unexpected
//  fail            out  1             sticky: any mismatch since start
//  unexpected      out  1             sticky: rd_valid seen while not in CHECK
//  err_count       out  ERRCNT_WIDTH  mismatching beats; saturates at all-ones
//  first_err_beat  out  BEAT_WIDTH    index of the first mismatching beat
//  lane_err_mask   out  NUM_LANES     sticky OR of per-lane mismatches
// BEHAVIOUR
//  Reset: state IDLE; every output 0; lane LFSRs = lane seeds.
//  LFSR step per lane (x^8+x^4+x^3+x^2+1, Galois): next = {q[6:0],1'b0} ^ (q[7] ? 8'h1D : 8'h00).
//  Expected beat n = concatenation of lane LFSRs after n steps; lane 0 occupies bits [7:0].
//  FSM transitions:
//   IDLE  -> CHECK on start. Reseed lanes, latch num_beats, clear status.
//            num_beats == 0 goes straight to DONE.
//   CHECK -> on rd_valid: compare, step all lanes, increment beat_cnt.
//            Last beat (beat_cnt == num_beats-1) goes to DONE.
//            No rd_valid: LFSRs and counters hold.
//   DONE  -> holds until start, then behaves as from IDLE.
//  Latency: status registered; err_count, fail and mask update on the cycle after the beat.
//   done/pass assert on the cycle after the last beat.
//  Mismatch beat: err_count += 1 unless already saturated.
//   Set fail; OR the lane diff mask into lane_err_mask.
//   If this is the first mismatch, first_err_beat = beat_cnt.
//  start during CHECK or DONE: abort and restart; a same-cycle rd_valid is ignored.
//  rd_valid in IDLE/DONE: set unexpected; no compare; LFSRs hold. Cleared only by start or reset.
//  reset mid-operation: immediate return to reset values; no partial status is retained.
// STRUCTURE
//  Package ddr_ex_pkg:
//   - state enum {IDLE, CHECK, DONE};
//   - LFSR8_TAPS = 8'h1D;
//   - function lfsr8_next(q).
//  Sub-module ddr_ex_lfsr8_lane, generated once per lane:
//   - 8-bit Galois LFSR with seed parameter and synchronous reseed;
//   - steps when its step input is high.
//  Top level holds the FSM, beat counter, comparators and status registers.
// TESTING  (DATA_WIDTH=16, SEED=32, lane seeds 0x20/0x21)
//  1 num_beats=4, start, beats 0x2120,0x4240,0x8480,0x151D back-to-back
//    -> done and pass one cycle after beat 3; err_count=0.
//  2 As 1 but beat 2 = 0x8481
//    -> fail=1, err_count=1, first_err_beat=2, lane_err_mask=2'b01, pass=0.
//  3 As 1 with rd_valid idle 1-3 cycles between beats
//    -> pass=1; expected data held across gaps.
//  4 num_beats=0, start -> done=1 next cycle, pass=1, busy never 1.
//  5 reset pulse after beat 1 of scenario 1, then start and replay all 4 beats
//    -> all outputs 0 during reset; final pass=1.
//  6 ERRCNT_WIDTH=2: 5 wrong beats -> err_count=3 (saturated).
//    Then rd_valid in DONE -> unexpected=1, pass=0; next start clears both.

Source files
------------

// File: rtl/ddr_ex_pkg.sv
// Shared types and the LFSR step function for the DDR example read checker.
package ddr_ex_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Galois taps for x^8 + x^4 + x^3 + x^2 + 1.
   localparam logic [7:0] LFSR8_TAPS = 8'h1D;

   // One Galois step: shift left, fold the outgoing MSB back through the taps.
   function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
      return {q[6:0], 1'b0} ^ (q[7] ? LFSR8_TAPS : 8'h00);
   endfunction

endpackage

// File: rtl/ddr_ex_lfsr8_lane.sv
// One byte lane of the expected-pattern generator: 8-bit Galois LFSR with a
// fixed seed, synchronous reseed and a step enable.
module ddr_ex_lfsr8_lane
   import ddr_ex_pkg::*;
#(
   parameter logic [7:0] SEED = 8'h01
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       reseed,
   input  logic       step,
   output logic [7:0] q
);

   // Lane register: reseed has priority so a restart always begins at beat 0.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of the others, independent of block order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= SEED;
      end else if (reseed) begin
         q <= SEED;
      end else if (step) begin
         q <= lfsr8_next(q);
      end
   end

endmodule

// File: rtl/ddr_ex_read_checker.sv
// Regenerates the LFSR write pattern per byte lane, compares it against
// read-back beats and keeps sticky pass/fail status for the test driver.
module ddr_ex_read_checker
   import ddr_ex_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int SEED         = 32,
   parameter int BEAT_WIDTH   = 16,
   parameter int ERRCNT_WIDTH = 16,
   localparam int NUM_LANES   = DATA_WIDTH / 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [BEAT_WIDTH-1:0]   num_beats,
   input  logic                    rd_valid,
   input  logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic                    fail,
   output logic                    unexpected,
   output logic [ERRCNT_WIDTH-1:0] err_count,
   output logic [BEAT_WIDTH-1:0]   first_err_beat,
   output logic [NUM_LANES-1:0]    lane_err_mask
);

   if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8) begin : g_bad_width
      $error("ddr_ex_read_checker: DATA_WIDTH must be a positive multiple of 8");
   end

   if (SEED < 1 || SEED + NUM_LANES - 1 > 255) begin : g_bad_seed
      $error("ddr_ex_read_checker: lane seeds SEED..SEED+NUM_LANES-1 must lie in 1..255");
   end

   state_t                  state;
   logic [BEAT_WIDTH-1:0]   beat_cnt;
   logic [BEAT_WIDTH-1:0]   beat_total;
   logic [DATA_WIDTH-1:0]   expected;
   logic [NUM_LANES-1:0]    lane_diff;
   logic                    mismatch;
   logic                    beat_accept;
   logic                    last_beat;

   // A start in the same cycle as rd_valid wins; that beat is discarded.
   assign beat_accept = (state == CHECK) && rd_valid && !start;
   assign last_beat   = (beat_cnt == beat_total - BEAT_WIDTH'(1));
   assign mismatch    = |lane_diff;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      ddr_ex_lfsr8_lane #(
         .SEED (8'(SEED + i))
      ) u_lane (
         .clk    (clk),
         .reset  (reset),
         .reseed (start),
         .step   (beat_accept),
         .q      (expected[8*i +: 8])
      );

      assign lane_diff[i] = (rd_data[8*i +: 8] != expected[8*i +: 8]);
   end

   assign busy = (state == CHECK);
   assign done = (state == DONE);

   // Checker FSM with beat counter and sticky status registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         beat_cnt       <= '0;
         beat_total     <= '0;
         pass           <= 1'b0;
         fail           <= 1'b0;
         unexpected     <= 1'b0;
         err_count      <= '0;
         first_err_beat <= '0;
         lane_err_mask  <= '0;
      end else if (start) begin
         beat_cnt       <= '0;
         beat_total     <= num_beats;
         fail           <= 1'b0;
         unexpected     <= 1'b0;
         err_count      <= '0;
         first_err_beat <= '0;
         lane_err_mask  <= '0;
         if (num_beats == '0) begin
            state <= DONE;
            pass  <= 1'b1;
         end else begin
            state <= CHECK;
            pass  <= 1'b0;
         end
      end else begin
         case (state)
            CHECK: begin
               if (rd_valid) begin
                  beat_cnt <= beat_cnt + BEAT_WIDTH'(1);
                  if (mismatch) begin
                     if (err_count != '1) begin
                        err_count <= err_count + ERRCNT_WIDTH'(1);
                     end
                     if (!fail) begin
                        first_err_beat <= beat_cnt;
                     end
                     fail          <= 1'b1;
                     lane_err_mask <= lane_err_mask | lane_diff;
                  end
                  if (last_beat) begin
                     state <= DONE;
                     // unexpected cannot be set while in CHECK, so only errors matter here.
                     pass  <= (err_count == '0) && !mismatch;
                  end
               end
            end
            default: begin
               if (rd_valid) begin
                  unexpected <= 1'b1;
                  pass       <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule
